// File: rtl/ram_loader_if.sv
// Byte-stream input and RAM write port of the boot loader, bundled for port hookup.
// The master side produces the stream and observes the RAM port; the slave is the loader.
interface ram_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_din;
  logic              ram_we;

  modport master (
    output in_data, in_valid,
    input  in_ready, ram_addr, ram_din, ram_we
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/ram_loader.sv
// Boot-time loader: parses MAGIC, LEN, {lo,hi} pairs and an XOR checksum from a byte
// stream, writing little-endian 16-bit words to consecutive RAM addresses from 0.
module ram_loader #(
  parameter int          ADDR_W         = 8,
  parameter logic [7:0]  MAGIC          = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1200000
) (
  input  logic         clk,
  input  logic         rst_n,
  ram_loader_if.slave  bus,
  input  logic         restart,
  output logic         mem_sel,
  output logic         done,
  output logic         error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_LO, S_HI, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] count_q, idx_q, addr_q;
  logic [7:0]        lo_q, csum_q;
  logic [15:0]       din_q;
  logic              we_q;
  logic [TW-1:0]     timer_q;
  logic              in_frame, xfer, timeout;

  assign in_frame = (state_q == S_LEN) || (state_q == S_LO) ||
                    (state_q == S_HI)  || (state_q == S_CSUM);
  assign xfer     = bus.in_valid && bus.in_ready;
  // An accepted byte beats an expiring timer in the same cycle.
  assign timeout  = in_frame && !xfer && (timer_q == TIMER_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (xfer && bus.in_data == MAGIC) state_d = S_LEN;
      S_LEN:  if (xfer) state_d = S_LO; else if (timeout) state_d = S_ERR;
      S_LO:   if (xfer) state_d = S_HI; else if (timeout) state_d = S_ERR;
      S_HI: begin
        if (xfer)         state_d = (idx_q == count_q) ? S_CSUM : S_LO;
        else if (timeout) state_d = S_ERR;
      end
      S_CSUM: begin
        if (xfer)         state_d = (bus.in_data == csum_q) ? S_DONE : S_ERR;
        else if (timeout) state_d = S_ERR;
      end
      S_DONE, S_ERR: if (restart) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = 1'b0;
    mem_sel      = 1'b0;
    done         = 1'b0;
    error        = 1'b0;
    unique case (state_q)
      S_IDLE:                    bus.in_ready = 1'b1;
      S_LEN, S_LO, S_HI, S_CSUM: begin
        bus.in_ready = 1'b1;
        mem_sel      = 1'b1;
      end
      S_DONE:                    done  = 1'b1;
      S_ERR:                     error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      lo_q    <= '0;
      csum_q  <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      timer_q <= '0;
    end else begin
      we_q <= 1'b0;
      if (xfer || !in_frame) timer_q <= '0;
      else                   timer_q <= timer_q + TW'(1);

      if (xfer) begin
        unique case (state_q)
          S_LEN: begin
            count_q <= ADDR_W'(bus.in_data);
            idx_q   <= '0;
            csum_q  <= '0;
          end
          S_LO: begin
            lo_q   <= bus.in_data;
            csum_q <= csum_q ^ bus.in_data;
          end
          S_HI: begin
            csum_q <= csum_q ^ bus.in_data;
            we_q   <= 1'b1;
            addr_q <= idx_q;
            din_q  <= {bus.in_data, lo_q};
            // Compare before increment so a full-size image never wraps the index.
            if (idx_q != count_q) idx_q <= idx_q + ADDR_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.ram_we   = we_q;
  assign bus.ram_addr = addr_q;
  assign bus.ram_din  = din_q;

endmodule
